// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the IF/LS memory port arbiter
package mem_port_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_ISSUE = 2'd1;
  localparam arb_state_t ST_WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  function automatic int streak_inc(int cur, int max);
    return (cur < max) ? cur + 1 : max;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// rtl/mem_lat_counter.sv - loadable down-counter timing the memory read latency
module mem_lat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_LAT        = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_ready,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(MAX_DATA_BURST + 1);

  arb_state_t        state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              drop_q, drop_d;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;

  logic grant, ls_win, lat_zero, resp;

  // LS wins unless it has starved a waiting fetch for a full burst
  assign ls_win = ls_req && !(if_req && streak_q == SW'(MAX_DATA_BURST));
  assign grant  = (state_q == ST_IDLE) && (ls_req || if_req);

  mem_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat (
    .clk    (clk),
    .reset  (reset),
    .load_i (state_q == ST_ISSUE),
    .en_i   (state_q == ST_WAIT),
    .zero_o (lat_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ls_req || if_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (lat_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (state_q == ST_IDLE) begin
      if (!if_req) begin
        streak_d = '0;
      end else if (ls_win) begin
        streak_d = SW'(streak_inc(int'(streak_q), MAX_DATA_BURST));
      end else begin
        streak_d = '0;
      end
    end
  end

  // A flush only matters while a fetch is actually in flight
  always_comb begin
    drop_d = drop_q;
    if (grant) begin
      drop_d = 1'b0;
    end else if (state_q != ST_IDLE && owner_q == OWN_IF && if_flush) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      drop_q      <= 1'b0;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
      if (grant) begin
        owner_q     <= ls_win ? OWN_LS : OWN_IF;
        we_q        <= ls_win && ls_we;
        mem_addr_q  <= ls_win ? ls_addr : if_addr;
        mem_wdata_q <= ls_win ? ls_wdata : '0;
        mem_be_q    <= ls_win ? ls_be : '1;
      end
    end
  end

  assign resp      = (state_q == ST_WAIT) && lat_zero;
  assign if_ready  = resp && (owner_q == OWN_IF) && !drop_q && !if_flush;
  assign ls_ready  = resp && (owner_q == OWN_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;
  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_ready;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        busy;

  typedef struct {
    logic        is_ls;
    logic        is_store;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          total;
  int          bad;
  int          now;
  int          t0;
  logic        prev_en;
  logic [31:0] pa1, pa2;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_DATA_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h200: return 32'hCAFEF00D;
      default: return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  // Two-cycle read pipeline: data for the mem_en cycle appears MEM_LAT cycles later
  always @(posedge clk) begin
    pa1 <= mem_addr;
    pa2 <= pa1;
  end
  assign mem_rdata = mem_val(pa2);

  task automatic check1(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(logic is_ls, logic is_store, logic [31:0] data, int cyc);
    exp_t e;
    e.is_ls    = is_ls;
    e.is_store = is_store;
    e.data     = data;
    e.cyc      = cyc;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    check1("two_readies", if_ready & ls_ready, 1'b0);
    check1("mem_en_b2b", prev_en & mem_en, 1'b0);
    if (if_ready || ls_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected observed=ready(if=%b ls=%b) expected=none at cycle %0d",
               if_ready, ls_ready, now);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check1("sb_owner", ls_ready, e.is_ls);
        check32("sb_cycle", now, e.cyc);
        if (!e.is_store) check32("sb_data", ls_ready ? ls_rdata : if_rdata, e.data);
      end
    end
    prev_en = mem_en;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    now++;
  endtask

  initial begin
    total = 0; bad = 0; now = 0; prev_en = 1'b0;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    sample();
    check1("rst_busy", busy, 1'b0);
    check1("rst_mem_en", mem_en, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_mem_wdata", mem_wdata, 32'h0);
    check32("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check1("rst_if_ready", if_ready, 1'b0);
    check1("rst_ls_ready", ls_ready, 1'b0);
    next();

    // single fetch
    t0 = now; if_req = 1'b1; if_addr = 32'h100;
    push(1'b0, 1'b0, 32'hDEADBEEF, t0 + 3);
    sample(); check1("t1_c0_en", mem_en, 1'b0); next();
    sample();
    check1("t1_c1_en", mem_en, 1'b1);
    check32("t1_c1_addr", mem_addr, 32'h100);
    check32("t1_c1_be", {28'h0, mem_be}, 32'hF);
    check1("t1_c1_we", mem_we, 1'b0);
    check1("t1_c1_busy", busy, 1'b1);
    next();
    sample(); check1("t1_c2_rdy", if_ready, 1'b0); next();
    sample();
    check1("t1_c3_rdy", if_ready, 1'b1);
    check32("t1_c3_data", if_rdata, 32'hDEADBEEF);
    next();
    if_req = 1'b0;
    sample(); check1("t1_c4_rdy", if_ready, 1'b0); check1("t1_c4_busy", busy, 1'b0); next();
    check32("t1_pending", exp_q.size(), 32'd0);

    // simultaneous requests: LS first, IF at the next grant slot
    t0 = now; if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_be = 4'hF;
    push(1'b1, 1'b0, 32'hCAFEF00D, t0 + 3);
    push(1'b0, 1'b0, mem_val(32'h300), t0 + 7);
    for (int c = 0; c < 9; c++) begin
      if (c == 4) ls_req = 1'b0;
      if (c == 8) if_req = 1'b0;
      sample();
      if (c == 1) check32("t2_ls_addr", mem_addr, 32'h200);
      if (c == 5) check32("t2_if_addr", mem_addr, 32'h300);
      check1("t2_en", mem_en, (c == 1 || c == 5));
      next();
    end
    check32("t2_pending", exp_q.size(), 32'd0);

    // starvation bound: 4 LS, 1 IF, then LS again
    t0 = now; ls_req = 1'b1; ls_addr = 32'h400; if_req = 1'b1; if_addr = 32'h500;
    for (int k = 0; k < 6; k++)
      push(k != 4, 1'b0, mem_val(k == 4 ? 32'h500 : 32'h400), t0 + 4 * k + 3);
    for (int c = 0; c < 24; c++) begin
      sample();
      if (c % 4 == 1) begin
        check1("t3_en", mem_en, 1'b1);
        check32("t3_addr", mem_addr, (c / 4 == 4) ? 32'h500 : 32'h400);
      end else begin
        check1("t3_en_lo", mem_en, 1'b0);
      end
      next();
    end
    ls_req = 1'b0; if_req = 1'b0;
    sample(); check1("t3_idle", busy, 1'b0); next();
    check32("t3_pending", exp_q.size(), 32'd0);

    // flush while fetch in WAIT
    t0 = now; if_req = 1'b1; if_addr = 32'h600;
    sample(); next();
    sample(); check1("t4_en", mem_en, 1'b1); next();
    if_flush = 1'b1; if_req = 1'b0;
    sample(); check1("t4_c2_rdy", if_ready, 1'b0); next();
    if_flush = 1'b0;
    sample(); check1("t4_c3_rdy", if_ready, 1'b0); check1("t4_c3_busy", busy, 1'b1); next();
    sample(); check1("t4_c4_rdy", if_ready, 1'b0); check1("t4_c4_busy", busy, 1'b0); next();

    // flush coinciding with the ready cycle
    if_req = 1'b1; if_addr = 32'h700;
    for (int c = 0; c < 5; c++) begin
      if_flush = (c == 3);
      if (c == 4) if_req = 1'b0;
      sample();
      check1("t4b_rdy", if_ready, 1'b0);
      next();
    end
    if_flush = 1'b0;

    // flush in IDLE with a replacement fetch has no effect
    t0 = now; if_req = 1'b1; if_addr = 32'h800; if_flush = 1'b1;
    push(1'b0, 1'b0, mem_val(32'h800), t0 + 3);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) if_flush = 1'b0;
      if (c == 4) if_req = 1'b0;
      sample(); next();
    end
    check32("t4c_pending", exp_q.size(), 32'd0);

    // store
    t0 = now; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h12345678; ls_be = 4'b0011;
    push(1'b1, 1'b1, 32'h0, t0 + 3);
    sample(); next();
    sample();
    check1("t5_en", mem_en, 1'b1);
    check1("t5_we", mem_we, 1'b1);
    check32("t5_addr", mem_addr, 32'h40);
    check32("t5_wdata", mem_wdata, 32'h12345678);
    check32("t5_be", {28'h0, mem_be}, 32'h3);
    next();
    sample(); check1("t5_we_lo", mem_we, 1'b0); next();
    sample(); check1("t5_rdy", ls_ready, 1'b1); next();
    ls_req = 1'b0; ls_we = 1'b0;
    sample(); next();
    check32("t5_pending", exp_q.size(), 32'd0);

    // reset mid-access
    ls_req = 1'b1; ls_addr = 32'h900; ls_be = 4'hF;
    sample(); next();
    sample(); check1("t6_en", mem_en, 1'b1); next();
    reset = 1'b1;
    sample(); next();
    reset = 1'b0; ls_req = 1'b0;
    sample();
    check1("t6_busy", busy, 1'b0);
    check1("t6_en_lo", mem_en, 1'b0);
    check1("t6_rdy", ls_ready, 1'b0);
    check32("t6_addr", mem_addr, 32'h0);
    check32("t6_be", {28'h0, mem_be}, 32'h0);
    next();
    sample(); check1("t6_rdy2", ls_ready, 1'b0); next();

    t0 = now; if_req = 1'b1; if_addr = 32'h100;
    push(1'b0, 1'b0, 32'hDEADBEEF, t0 + 3);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) if_req = 1'b0;
      sample();
      if (c == 1) check32("t6_if_addr", mem_addr, 32'h100);
      next();
    end
    check32("t6_pending", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
